// File: rtl/output_buffer_load_ctrl.sv
// -----------------------------------------------------------------------------
// output_buffer_load_ctrl
// Sequences one output-buffer transaction: write strobes, an optional
// shift/accumulate phase, then a word-by-word load handed to the RISC-V side
// through a valid/ready handshake.
//
// Ports
//   clk_i               clock, all state changes on the rising edge
//   rst_i               synchronous active-high reset
//   start_i             request one sequence (accepted only in IDLE)
//   mode_i[1:0]         1 = read, 2/3 = PIM, 0 = illegal (error pulse)
//   shift_len_i[3:0]    shift cycles for PIM mode (0 -> 1, clamps to MAX_SHIFT)
//   abort_i             cancel the running sequence
//   word_ready_i        RISC-V side accepts the presented word
//   buf_write_en_*_o    output-buffer write strobes
//   shift_counter_en_o  shift/accumulate enable
//   load_en_o           load strobe
//   load_cnt_o[5:0]     index of the word being loaded
//   before_load_mode_o  mode latched at start (0 in IDLE)
//   word_valid_o        presented word is valid
//   busy_o              high in any non-IDLE state
//   done_o              one-cycle completion pulse
//   err_o               one-cycle pulse on an illegal start
// -----------------------------------------------------------------------------
module output_buffer_load_ctrl #(
   parameter int unsigned NUM_GROUPS = 32,
   parameter int unsigned MAX_SHIFT  = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [1:0] mode_i,
   input  logic [3:0] shift_len_i,
   input  logic       abort_i,
   input  logic       word_ready_i,
   output logic       buf_write_en_0_o,
   output logic       buf_write_en_1_o,
   output logic       buf_write_en_2_o,
   output logic       shift_counter_en_o,
   output logic       load_en_o,
   output logic [5:0] load_cnt_o,
   output logic [1:0] before_load_mode_o,
   output logic       word_valid_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   localparam int unsigned IDX_W  = 6;
   localparam int unsigned SLEN_W = 4;
   localparam logic [IDX_W-1:0]  LAST_PIM    = IDX_W'(NUM_GROUPS - 1);
   localparam logic [SLEN_W-1:0] MAX_SHIFT_L = SLEN_W'(MAX_SHIFT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR0   = 3'd1,
      S_WR1   = 3'd2,
      S_WR2   = 3'd3,
      S_SHIFT = 3'd4,
      S_LOAD  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        mode_q, mode_d;
   logic [SLEN_W-1:0] slen_q, slen_d;
   logic [SLEN_W-1:0] scnt_q, scnt_d;

   logic              buf_write_en_0_q, buf_write_en_0_d;
   logic              buf_write_en_1_q, buf_write_en_1_d;
   logic              buf_write_en_2_q, buf_write_en_2_d;
   logic              shift_counter_en_q, shift_counter_en_d;
   logic              load_en_q, load_en_d;
   logic [IDX_W-1:0]  load_cnt_q, load_cnt_d;
   logic [1:0]        before_load_mode_q, before_load_mode_d;
   logic              word_valid_q, word_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [SLEN_W-1:0] slen_clamp;
   logic [IDX_W-1:0]  last_idx;
   logic              xfer;

   // Shift length as used by the sequence: zero means one cycle, large values saturate.
   assign slen_clamp = (shift_len_i == '0)         ? SLEN_W'(1)  :
                       (shift_len_i > MAX_SHIFT_L) ? MAX_SHIFT_L : shift_len_i;

   // Read mode loads a single word; PIM modes load one word per group.
   assign last_idx = (mode_q == 2'd1) ? '0 : LAST_PIM;

   // word_valid_q is high exactly in LOAD, so this is the handshake.
   assign xfer = (state_q == S_LOAD) && word_ready_i;

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q            <= S_IDLE;
         idx_q              <= '0;
         mode_q             <= '0;
         slen_q             <= '0;
         scnt_q             <= '0;
         buf_write_en_0_q   <= 1'b0;
         buf_write_en_1_q   <= 1'b0;
         buf_write_en_2_q   <= 1'b0;
         shift_counter_en_q <= 1'b0;
         load_en_q          <= 1'b0;
         load_cnt_q         <= '0;
         before_load_mode_q <= '0;
         word_valid_q       <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         err_q              <= 1'b0;
      end else begin
         state_q            <= state_d;
         idx_q              <= idx_d;
         mode_q             <= mode_d;
         slen_q             <= slen_d;
         scnt_q             <= scnt_d;
         buf_write_en_0_q   <= buf_write_en_0_d;
         buf_write_en_1_q   <= buf_write_en_1_d;
         buf_write_en_2_q   <= buf_write_en_2_d;
         shift_counter_en_q <= shift_counter_en_d;
         load_en_q          <= load_en_d;
         load_cnt_q         <= load_cnt_d;
         before_load_mode_q <= before_load_mode_d;
         word_valid_q       <= word_valid_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
         err_q              <= err_d;
      end
   end

   // Next state and counters; abort overrides everything outside IDLE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      slen_d  = slen_q;
      scnt_d  = scnt_q;
      err_d   = 1'b0;

      if ((state_q != S_IDLE) && abort_i) begin
         state_d = S_IDLE;
         idx_d   = '0;
         mode_d  = '0;
         scnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  if (mode_i == 2'd0) begin
                     err_d = 1'b1;
                  end else begin
                     mode_d  = mode_i;
                     slen_d  = slen_clamp;
                     idx_d   = '0;
                     scnt_d  = '0;
                     state_d = (mode_i == 2'd1) ? S_WR0 : S_WR1;
                  end
               end
            end
            S_WR0:   state_d = S_LOAD;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_SHIFT;
            S_SHIFT: begin
               if (scnt_q == slen_q - SLEN_W'(1)) begin
                  state_d = S_LOAD;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + SLEN_W'(1);
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  if (idx_q == last_idx) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               idx_d   = '0;
               mode_d  = '0;
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = '0;
               mode_d  = '0;
               scnt_d  = '0;
            end
         endcase
      end
   end

   // Moore decode of the upcoming state so outputs land in the same cycle as it.
   always_comb begin
      buf_write_en_0_d   = 1'b0;
      buf_write_en_1_d   = 1'b0;
      buf_write_en_2_d   = 1'b0;
      shift_counter_en_d = 1'b0;
      load_en_d          = 1'b0;
      load_cnt_d         = '0;
      before_load_mode_d = '0;
      word_valid_d       = 1'b0;
      busy_d             = 1'b0;
      done_d             = 1'b0;

      if (state_d != S_IDLE) begin
         busy_d             = 1'b1;
         before_load_mode_d = mode_d;
      end

      case (state_d)
         S_WR0:   buf_write_en_0_d   = 1'b1;
         S_WR1:   buf_write_en_1_d   = 1'b1;
         S_WR2:   buf_write_en_2_d   = 1'b1;
         S_SHIFT: shift_counter_en_d = 1'b1;
         S_LOAD: begin
            load_en_d    = 1'b1;
            word_valid_d = 1'b1;
            load_cnt_d   = idx_d;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   assign buf_write_en_0_o   = buf_write_en_0_q;
   assign buf_write_en_1_o   = buf_write_en_1_q;
   assign buf_write_en_2_o   = buf_write_en_2_q;
   assign shift_counter_en_o = shift_counter_en_q;
   assign load_en_o          = load_en_q;
   assign load_cnt_o         = load_cnt_q;
   assign before_load_mode_o = before_load_mode_q;
   assign word_valid_o       = word_valid_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign err_o              = err_q;

endmodule

// File: doc/output_buffer_load_ctrl.md
OUTPUT_BUFFER_LOAD_CTRL -- requirements
Module: output_buffer_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 32, number of mapping groups / words per PIM load (2..32).
REQ-002 SHALL have parameter MAX_SHIFT, default 8, maximum shift-counter cycles per sequence.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state changes on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  request to run one write/shift/load sequence.
REQ-007 mode_i  in  2  requested mode: 1 = read, 2/3 = PIM, 0 = illegal.
REQ-008 shift_len_i  in  4  shift-counter cycles for PIM mode; 0 treated as 1, values above MAX_SHIFT clamp to MAX_SHIFT.
REQ-009 abort_i  in  1  cancel the sequence in progress.
REQ-010 word_ready_i  in  1  RISC-V side accepts current word.
REQ-011 buf_write_en_0_o / buf_write_en_1_o / buf_write_en_2_o  out  1 each  output-buffer write strobes.
REQ-012 shift_counter_en_o  out  1  shift/accumulate enable.
REQ-013 load_en_o  out  1  load strobe to output buffer.
REQ-014 load_cnt_o  out  6  index of the word being loaded.
REQ-015 before_load_mode_o  out  2  mode latched at start.
REQ-016 word_valid_o  out  1  current out_buf word valid for RISC-V.
REQ-017 busy_o  out  1  high in any non-IDLE state.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 err_o  out  1  one-cycle pulse on illegal start.

Function
REQ-020 SHALL implement FSM states IDLE, WR0, WR1, WR2, SHIFT, LOAD, DONE; all outputs are registered (Moore), decoded from state/counters.
REQ-021 IDLE: start_i=1, abort_i=0 and mode_i!=0 -> latch mode_i into before_load_mode_o and clamped shift_len_i; next state WR0 if mode 1, else WR1.
REQ-022 IDLE: start_i=1, abort_i=0 and mode_i=0 -> stay IDLE, err_o=1 for the next cycle.
REQ-023 start_i outside IDLE SHALL be ignored, with no error pulse.
REQ-024 WR0: buf_write_en_0_o=1 for exactly one cycle -> LOAD.
REQ-025 WR1: buf_write_en_1_o=1 for one cycle -> WR2.
REQ-026 WR2: buf_write_en_2_o=1 for one cycle -> SHIFT.
REQ-027 SHIFT: shift_counter_en_o=1 for exactly the latched shift length in consecutive cycles -> LOAD.
REQ-028 LOAD: load_en_o=1, word_valid_o=1, load_cnt_o=current index (starting at 0).
REQ-029 LOAD handshake: a word transfers in any cycle with word_valid_o and word_ready_i both high.
  - On transfer with index < last: increment index; next word is presented the following cycle.
  - On transfer with index = last: go to DONE.
  - Without word_ready_i: hold index, load_en_o and word_valid_o.
REQ-030 last index SHALL be 0 in mode 1 and NUM_GROUPS-1 in modes 2/3; the index never wraps.
REQ-031 DONE: done_o=1 for one cycle -> IDLE.
REQ-032 before_load_mode_o SHALL hold the latched mode from WR0/WR1 through DONE, and SHALL be 0 in IDLE.
REQ-033 All strobe outputs and load_cnt_o SHALL be 0 in any state that does not drive them.
REQ-034 abort_i=1 in any non-IDLE state -> IDLE next cycle.
  - All outputs return to reset values.
  - No done_o pulse.
  - abort_i takes priority over word_ready_i and over start_i.
REQ-035 Latency: start_i sampled at edge k puts the first strobe high in the cycle after edge k.
REQ-036 A mode 2/3 sequence with zero stall and shift length S SHALL take 2+S+NUM_GROUPS+1 cycles from first strobe to done_o.

Reset
REQ-037 rst_i=1 at an edge SHALL force IDLE, index 0 and latched mode 0, with all outputs 0, on the next cycle, regardless of state (including mid-LOAD).
REQ-038 Reset SHALL take priority over start_i and abort_i in the same cycle.

Verification
REQ-039 Mode 1: start, word_ready_i held 1 -> WR0 1 cycle, then 1 LOAD cycle with load_cnt_o=0 and before_load_mode_o=1, then done_o; 3 cycles total.
REQ-040 Mode 2, shift_len_i=3, NUM_GROUPS=32, ready always 1 -> write_en_1, write_en_2, 3 shift cycles, load_cnt_o 0..31, done_o on cycle 38.
REQ-041 Mode 3 with word_ready_i low 4 cycles at index 5 -> load_cnt_o held at 5 and word_valid_o held high; 6 follows after ready rises; exactly 32 transfers.
REQ-042 mode_i=0 start -> err_o pulse, busy_o stays 0; shift_len_i=0 -> 1 shift cycle; shift_len_i=15 -> 8 shift cycles.
REQ-043 abort_i at index 10 -> IDLE next cycle, no done_o; a new start is accepted the following cycle.
REQ-044 rst_i mid-SHIFT -> all outputs 0 next cycle; start_i asserted while busy is ignored.
